// File: rtl/bus_xfer_arbiter.sv
// bus_xfer_arbiter: grants the shared tri-state data bus to one of NUM_REQ
// requesters at a time and drives the per-device CS/OE/EN/CNT_EN strobes for a
// single register-to-register transfer (source drives the bus, destination loads).
// The sequence is IDLE -> XFER | REJ -> TURN -> IDLE, so there is at most one
// transfer every three cycles. The TURN cycle keeps every strobe low so that two
// drivers never overlap on the bus.
// All outputs are registered.
// Configuration macro: BUS_ARB_FIXED_PRI_EN
//   - When it is defined, the lowest requester index always wins and rr_ptr is held at 0.
//   - When it is undefined (the default), arbitration is round-robin starting at rr_ptr.
module bus_xfer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int NUM_DEV = 8,
    parameter int SEL_W   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*SEL_W-1:0] req_src_i,
    input  logic [NUM_REQ*SEL_W-1:0] req_dst_i,
    input  logic [NUM_REQ-1:0]       req_inc_i,
    output logic [NUM_REQ-1:0]       ack_o,
    output logic                     err_o,
    output logic [NUM_DEV-1:0]       cs_o,
    output logic [NUM_DEV-1:0]       oe_o,
    output logic [NUM_DEV-1:0]       en_o,
    output logic [NUM_DEV-1:0]       cnt_en_o,
    output logic                     busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_REJ  = 2'd2,
        S_TURN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [PTR_W-1:0]   pick;
    logic [SEL_W-1:0]   src_w, dst_w;
    logic               inc_w;

    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               err_q, err_d;
    logic [NUM_DEV-1:0] cs_q, cs_d;
    logic [NUM_DEV-1:0] oe_q, oe_d;
    logic [NUM_DEV-1:0] en_q, en_d;
    logic [NUM_DEV-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;

    // Returns the first requesting index at or after ptr, wrapping around.
    // With ptr fixed at 0, this reduces to lowest-index priority.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [PTR_W-1:0]   ptr);
        logic [PTR_W-1:0] w;
        logic             found;
        int               idx;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && r[idx]) begin
                w     = PTR_W'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // Decodes a device index into a one-hot strobe vector.
    // Out-of-range selects decode to all zeros.
    function automatic logic [NUM_DEV-1:0] dev_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_DEV-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_DEV; k++) begin
            v[k] = (int'(sel) == k);
        end
        return v;
    endfunction

    // A transfer is legal only between two distinct devices that both exist.
    function automatic logic xfer_ok(input logic [SEL_W-1:0] s, input logic [SEL_W-1:0] d);
        return (s != d) && (int'(s) < NUM_DEV) && (int'(d) < NUM_DEV);
    endfunction

    // Winner selection and its request fields, which are sampled only on the arbitration edge.
    always_comb begin
        pick  = rr_pick(req_i, rr_ptr_q);
        src_w = req_src_i[int'(pick)*SEL_W +: SEL_W];
        dst_w = req_dst_i[int'(pick)*SEL_W +: SEL_W];
        inc_w = req_inc_i[pick];
    end

    // Next-state logic, and the values the output registers take on the next edge.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        ack_d    = '0;
        err_d    = 1'b0;
        cs_d     = '0;
        oe_d     = '0;
        en_d     = '0;
        cnt_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    win_d = pick;
                    ack_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                    if (xfer_ok(src_w, dst_w)) begin
                        state_d = S_XFER;
                        oe_d    = dev_onehot(src_w);
                        en_d    = dev_onehot(dst_w);
                        cs_d    = dev_onehot(src_w) | dev_onehot(dst_w);
                        cnt_d   = inc_w ? dev_onehot(src_w) : '0;
                    end else begin
                        state_d = S_REJ;
                        err_d   = 1'b1;
                    end
                end
            end
            S_XFER, S_REJ: begin
                state_d = S_TURN;
`ifdef BUS_ARB_FIXED_PRI_EN
                rr_ptr_d = '0;
`else
                rr_ptr_d = (win_q == PTR_W'(NUM_REQ-1)) ? '0 : win_q + 1'b1;
`endif
            end
            S_TURN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Control state: the FSM state and the round-robin pointer. A reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Registered strobes and handshake. A reset clears them on the same edge, so the aborted request gets no ack.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ack_q  <= '0;
            err_q  <= 1'b0;
            cs_q   <= '0;
            oe_q   <= '0;
            en_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            ack_q  <= ack_d;
            err_q  <= err_d;
            cs_q   <= cs_d;
            oe_q   <= oe_d;
            en_q   <= en_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // Latched winner index. It is read only in XFER/REJ to advance the pointer.
    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    assign ack_o    = ack_q;
    assign err_o    = err_q;
    assign cs_o     = cs_q;
    assign oe_o     = oe_q;
    assign en_o     = en_q;
    assign cnt_en_o = cnt_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_bus_xfer_arbiter.sv
// Bench for bus_xfer_arbiter: directed scenarios followed by randomized requests.
// The reference model is a transaction-level one: a round-robin scan (or
// lowest-index scan) over the request vector, plus a small array of bus devices
// that reacts to the DUT's strobes.
module tb_bus_xfer_arbiter;

    localparam int NREQ = 4;
    localparam int NDEV = 8;
    localparam int SW   = 3;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_i;
    logic [NREQ*SW-1:0] req_src_i;
    logic [NREQ*SW-1:0] req_dst_i;
    logic [NREQ-1:0]   req_inc_i;
    logic [NREQ-1:0]   ack_o;
    logic              err_o;
    logic [NDEV-1:0]   cs_o, oe_o, en_o, cnt_en_o;
    logic              busy_o;

    int vectors     = 0;
    int miscompares = 0;
    int rr          = 0;
    logic [7:0] dev [NDEV];

    bus_xfer_arbiter #(.NUM_REQ(NREQ), .NUM_DEV(NDEV), .SEL_W(SW)) dut (
        .clk(clk), .reset(reset),
        .req_i(req_i), .req_src_i(req_src_i), .req_dst_i(req_dst_i), .req_inc_i(req_inc_i),
        .ack_o(ack_o), .err_o(err_o), .cs_o(cs_o), .oe_o(oe_o), .en_o(en_o),
        .cnt_en_o(cnt_en_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus devices: the enabled source drives the bus, and the enabled destination loads it at the edge ending XFER.
    always @(posedge clk) begin
        logic [7:0] bus;
        bus = 8'h00;
        for (int k = 0; k < NDEV; k++) if (oe_o[k]) bus = dev[k];
        for (int k = 0; k < NDEV; k++) begin
            if (en_o[k])     dev[k] <= bus;
            if (cnt_en_o[k]) dev[k] <= dev[k] + 8'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input logic exp_busy);
        chk({tag, "_ack"},  32'(ack_o), 32'd0);
        chk({tag, "_err"},  32'(err_o), 32'd0);
        chk({tag, "_cs"},   32'(cs_o), 32'd0);
        chk({tag, "_oe"},   32'(oe_o), 32'd0);
        chk({tag, "_en"},   32'(en_o), 32'd0);
        chk({tag, "_cnt"},  32'(cnt_en_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'(exp_busy));
    endtask

    task automatic set_req(input int i, input int s, input int d, input bit inc);
        req_i[i]           = 1'b1;
        req_src_i[i*SW +: SW] = SW'(s);
        req_dst_i[i*SW +: SW] = SW'(d);
        req_inc_i[i]       = inc;
    endtask

    // Model arbitration: with fixed priority the lowest index wins;
    // otherwise the winner is the first requester at or after rr, wrapping around.
    function automatic int model_pick(input logic [NREQ-1:0] r);
`ifdef BUS_ARB_FIXED_PRI_EN
        for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
        for (int k = 0; k < NREQ; k++) if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
`endif
        return -1;
    endfunction

    // One arbitration: this covers the XFER/REJ cycle, then the TURN cycle, then the return to IDLE.
    task automatic run_xact(input string tag, input bit drop);
        int w, s, d;
        bit inc, ok;
        logic [7:0] old_s;
        w = model_pick(req_i);
        if (w < 0) begin
            vectors++; miscompares++;
            $error("FAIL %s_nowinner: observed none expected a request", tag);
            return;
        end
        s     = int'(req_src_i[w*SW +: SW]);
        d     = int'(req_dst_i[w*SW +: SW]);
        inc   = req_inc_i[w];
        ok    = (s != d) && (s < NDEV) && (d < NDEV);
        old_s = dev[s];
        @(posedge clk); #1;
        chk({tag, "_ack"},    32'(ack_o), 32'(1) << w);
        chk({tag, "_err"},    32'(err_o), 32'(!ok));
        chk({tag, "_oe"},     32'(oe_o), ok ? (32'(1) << s) : 32'd0);
        chk({tag, "_en"},     32'(en_o), ok ? (32'(1) << d) : 32'd0);
        chk({tag, "_cs"},     32'(cs_o), ok ? ((32'(1) << s) | (32'(1) << d)) : 32'd0);
        chk({tag, "_cnt"},    32'(cnt_en_o), (ok && inc) ? (32'(1) << s) : 32'd0);
        chk({tag, "_oe_en"},  32'(oe_o & en_o), 32'd0);
        chk({tag, "_busy"},   32'(busy_o), 32'd1);
`ifndef BUS_ARB_FIXED_PRI_EN
        rr = (w + 1) % NREQ;
`endif
        if (drop) req_i[w] = 1'b0;
        @(posedge clk); #1;
        chk_quiet({tag, "_turn"}, 1'b1);
        if (ok) begin
            chk({tag, "_devdst"}, 32'(dev[d]), 32'(old_s));
            if (inc) chk({tag, "_devinc"}, 32'(dev[s]), 32'(old_s + 8'd1));
        end
        @(posedge clk); #1;
        chk_quiet({tag, "_idle"}, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < NDEV; k++) dev[k] = 8'(k * 17 + 3);
        reset = 1'b0; req_i = '0; req_src_i = '0; req_dst_i = '0; req_inc_i = '0;
        // Test 1: hold reset low for two cycles, then leave the arbiter idle.
        repeat (2) @(posedge clk);
        #1 chk_quiet("reset", 1'b0);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk_quiet("idle", 1'b0);
        end

        // Test 3: all four requesters held -> grants rotate in order.
        for (int i = 0; i < NREQ; i++) set_req(i, i, i + 4, 1'b0);
        for (int g = 0; g < 5; g++) run_xact("allreq", 1'b0);
        req_i = '0;

        // Test 2: a plain transfer from device 2 to device 5.
        set_req(1, 2, 5, 1'b0);
        run_xact("xfer25", 1'b1);

        // Test 4: src equal to dst is rejected.
        set_req(2, 3, 3, 1'b0);
        run_xact("rej33", 1'b1);

        // Test 5: a post-incremented PC counter is copied to device 1.
        set_req(0, 0, 1, 1'b1);
        run_xact("pcinc", 1'b1);

        // Test 6: a reset during the XFER cycle aborts the transfer.
        set_req(3, 4, 6, 1'b0);
        @(posedge clk); #1;
        chk("abort_oe", 32'(oe_o), 32'h10);
        reset = 1'b0; req_i = '0;
        @(posedge clk); #1;
        chk_quiet("abort", 1'b0);
        reset = 1'b1; rr = 0;
        @(posedge clk); #1;
        chk_quiet("postabort", 1'b0);

        // Randomized requests: losing requesters keep their request, and idle requesters may start a new one.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_i[i] && ($urandom_range(0, 1) == 1)) begin
                    int s, d;
                    s = $urandom_range(0, NDEV - 1);
                    d = ($urandom_range(0, 5) == 0) ? s : $urandom_range(0, NDEV - 1);
                    set_req(i, s, d, 1'($urandom_range(0, 1)));
                end
            end
            if (req_i == '0) set_req(int'($urandom_range(0, NREQ - 1)), 1, 2, 1'b0);
            run_xact("rand", 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
